hist_acq_scheduler: RTL and testbench

//  Schedules one histogram-builder write port (wrEn/data) shared by PIXELS pixel TDC channels.

---
 rtl/hist_acq_scheduler.sv | 138 +++++++++++++
 tb/tb_hist_acq_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hist_acq_scheduler.sv
// Shares one histogram-builder write port among PIXELS TDC channels over a frame of
// ACQ_NUM laser acquisitions. Each pixel has a one-deep buffer; buffers are granted round-robin.
module hist_acq_scheduler #(
  parameter int NP      = 10,
  parameter int PIXELS  = 3,
  parameter int ACQ_NUM = 4,
  parameter int PIX_W   = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 laser_sync,
  input  logic [PIXELS-1:0]    tdc_valid,
  input  logic [PIXELS*NP-1:0] tdc_data,
  output logic                 wrEn,
  output logic [NP-1:0]        data,
  output logic [PIX_W-1:0]     pix_sel,
  output logic                 acq_strobe,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          drop_cnt
);

  localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  typedef enum logic [2:0] {IDLE, ARM, ACQ, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ACQ_W-1:0]    acq_cnt;
  logic [PIXELS-1:0]   full;
  logic [NP-1:0]       hold [PIXELS];
  logic [PIX_W-1:0]    rr;

  logic                sync_ok, last_sync, cap_en, grant_vld;
  logic [PIX_W-1:0]    grant_idx;
  logic [PIXELS-1:0]   grant_oh, load, drop;
  logic [PIX_W:0]      drop_n;
  logic [16:0]         drop_sum;
  logic [15:0]         drop_nxt;

  always_comb begin
    state_nxt = state;
    sync_ok   = 1'b0;
    last_sync = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ARM;
      ARM:   if (laser_sync) begin
               state_nxt = ACQ;
               sync_ok   = 1'b1;
             end
      ACQ:   if (laser_sync) begin
               sync_ok = 1'b1;
               if (acq_cnt == ACQ_W'(ACQ_NUM - 1)) begin
                 last_sync = 1'b1;
                 state_nxt = DRAIN;
               end
             end
      DRAIN: if (full == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round-robin search starts one past the last granted pixel.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    if (state == ACQ || state == DRAIN) begin
      for (int k = 1; k <= PIXELS; k++) begin
        idx = (int'(rr) + k) % PIXELS;
        if (!grant_vld && full[idx]) begin
          grant_vld     = 1'b1;
          grant_idx     = PIX_W'(idx);
          grant_oh[idx] = 1'b1;
        end
      end
    end
  end

  // A buffer being granted this cycle can take a new hit without losing anything.
  always_comb begin
    cap_en = (state == ACQ) && !last_sync;
    load   = '0;
    drop   = '0;
    drop_n = '0;
    for (int i = 0; i < PIXELS; i++) begin
      load[i] = cap_en && tdc_valid[i] && (!full[i] || grant_oh[i]);
      drop[i] = cap_en && tdc_valid[i] && full[i] && !grant_oh[i];
      drop_n  = drop_n + {{PIX_W{1'b0}}, drop[i]};
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_n);
    drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      acq_cnt    <= '0;
      full       <= '0;
      rr         <= '0;
      wrEn       <= 1'b0;
      data       <= '0;
      pix_sel    <= '0;
      acq_strobe <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      acq_strobe <= sync_ok;
      if (state == ARM && laser_sync)
        acq_cnt <= '0;
      else if (state == ACQ && laser_sync && !last_sync)
        acq_cnt <= acq_cnt + 1'b1;
      if (state == IDLE && start)
        drop_cnt <= '0;
      else
        drop_cnt <= drop_nxt;
      wrEn <= grant_vld;
      if (grant_vld) begin
        data    <= hold[grant_idx];
        pix_sel <= grant_idx;
        rr      <= grant_idx;
      end
      full <= (full & ~grant_oh) | load;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIXELS; i++)
      if (load[i]) hold[i] <= tdc_data[i*NP +: NP];
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_hist_acq_scheduler.sv
// Directed bench for hist_acq_scheduler (NP=10, PIXELS=3, ACQ_NUM=4).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_hist_acq_scheduler;
  localparam int NP = 10, PIXELS = 3, ACQ_NUM = 4, PIX_W = 2;

  logic                 clk = 1'b0;
  logic                 res, start, laser_sync;
  logic [PIXELS-1:0]    tdc_valid;
  logic [PIXELS*NP-1:0] tdc_data;
  logic                 wrEn, acq_strobe, busy, frame_done;
  logic [NP-1:0]        data;
  logic [PIX_W-1:0]     pix_sel;
  logic [15:0]          drop_cnt;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_done = 0;

  hist_acq_scheduler #(.NP(NP), .PIXELS(PIXELS), .ACQ_NUM(ACQ_NUM)) dut (
    .clk(clk), .res(res), .start(start), .laser_sync(laser_sync),
    .tdc_valid(tdc_valid), .tdc_data(tdc_data), .wrEn(wrEn), .data(data),
    .pix_sel(pix_sel), .acq_strobe(acq_strobe), .busy(busy),
    .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acq_strobe) n_strobe++;
    if (frame_done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hit(input logic [2:0] v, input int d2, input int d1, input int d0);
    tdc_valid = v;
    tdc_data  = {NP'(d2), NP'(d1), NP'(d0)};
  endtask

  task automatic chk_wr(input string tag, input int d, input int p);
    chk({tag, "_wren"}, 32'(wrEn), 32'd1);
    chk({tag, "_data"}, 32'(data), 32'(d));
    chk({tag, "_pix"},  32'(pix_sel), 32'(p));
  endtask

  initial begin
    res = 1'b1; start = 1'b0; laser_sync = 1'b0;
    hit(3'b000, 0, 0, 0);
    step(); step();
    res = 1'b0;
    chk("rst_wren", 32'(wrEn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_strobe", 32'(acq_strobe), 0);
    chk("rst_data", 32'(data), 0);

    // frame A: arm, then start while busy must be ignored
    start = 1'b1; step(); start = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy_ignored", 32'(busy), 1);
    chk("arm_no_strobe", 32'(acq_strobe), 0);
    laser_sync = 1'b1; step(); laser_sync = 1'b0;
    chk("first_strobe", 32'(acq_strobe), 1);
    step();
    chk("strobe_one_cycle", 32'(acq_strobe), 0);

    // three simultaneous hits with rr=0 -> pixels 1,2,0
    hit(3'b111, 1022, 511, 108); step(); hit(3'b000, 0, 0, 0);
    chk("cap_no_wr", 32'(wrEn), 0);
    step(); chk_wr("rr_a", 511, 1);
    step(); chk_wr("rr_b", 1022, 2);
    step(); chk_wr("rr_c", 108, 0);
    step();
    chk("rr_idle_wren", 32'(wrEn), 0);
    chk("rr_hold_data", 32'(data), 108);

    // hit on pixel 0 in the same cycle it is granted
    hit(3'b001, 0, 0, 77); step();
    hit(3'b001, 0, 0, 88); step(); hit(3'b000, 0, 0, 0);
    chk_wr("same_old", 77, 0);
    step(); chk_wr("same_new", 88, 0);
    chk("same_nodrop", 32'(drop_cnt), 0);
    step();
    chk("same_end", 32'(wrEn), 0);

    // move rr to 1, then pixel 1 is held behind pixel 2 and its second hit is lost
    hit(3'b010, 0, 5, 0); step(); hit(3'b000, 0, 0, 0);
    step(); chk_wr("rr_to1", 5, 1);
    hit(3'b110, 300, 200, 0); step();
    hit(3'b010, 0, 90, 0); step(); hit(3'b000, 0, 0, 0);
    chk_wr("drop_w2", 300, 2);
    chk("drop_one", 32'(drop_cnt), 1);
    step(); chk_wr("drop_w1", 200, 1);
    step();
    chk("drop_end", 32'(wrEn), 0);
    chk("drop_keep", 32'(drop_cnt), 1);

    // remaining acquisitions: three non-final syncs, then the final one
    for (int i = 0; i < 3; i++) begin
      laser_sync = 1'b1; step(); laser_sync = 1'b0;
      step();
    end
    chk("acq_busy", 32'(busy), 1);
    hit(3'b001, 0, 0, 400); step();
    laser_sync = 1'b1; hit(3'b111, 3, 2, 1); step();
    laser_sync = 1'b0; hit(3'b000, 0, 0, 0);
    chk_wr("last_write", 400, 0);
    chk("last_strobe", 32'(acq_strobe), 1);
    chk("drain_busy", 32'(busy), 1);
    step();
    chk("done_pulse", 32'(frame_done), 1);
    chk("final_sync_not_cap", 32'(wrEn), 0);
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("done_one_cycle", 32'(frame_done), 0);
    chk("idle_wren", 32'(wrEn), 0);
    chk("strobe_count", 32'(n_strobe), 5);
    chk("done_count", 32'(n_done), 1);

    // laser_sync in IDLE is ignored
    laser_sync = 1'b1; step(); laser_sync = 1'b0;
    chk("idle_sync_busy", 32'(busy), 0);
    step();
    chk("idle_sync_strobe", 32'(n_strobe), 5);
    chk("drop_kept_idle", 32'(drop_cnt), 1);

    // frame B: drop_cnt cleared on start; multi-drop popcount; then abort by reset
    start = 1'b1; step(); start = 1'b0;
    chk("drop_cleared", 32'(drop_cnt), 0);
    laser_sync = 1'b1; step(); laser_sync = 1'b0;
    hit(3'b111, 30, 20, 10); step();
    hit(3'b111, 33, 22, 11); step(); hit(3'b000, 0, 0, 0);
    chk_wr("multi_w", 20, 1);
    chk("multi_drop", 32'(drop_cnt), 2);
    res = 1'b1; step();
    chk("abort_wren", 32'(wrEn), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_drop", 32'(drop_cnt), 0);
    step(); step(); res = 1'b0;
    step();
    chk("abort_no_done", 32'(n_done), 1);
    chk("abort_no_flush", 32'(wrEn), 0);

    // new frame after abort: buffers must be empty
    start = 1'b1; step(); start = 1'b0;
    laser_sync = 1'b1; step(); laser_sync = 1'b0;
    step();
    chk("post_abort_wren", 32'(wrEn), 0);
    step();
    chk("post_abort_wren2", 32'(wrEn), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
